fb_scanout: RTL
===============

FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameter FB_OFFSET, default 12'hF00, byte address of framebuffer base in shared memory.
REQ-002 Parameter FB_BYTES, default 256, framebuffer length (64x32 pixels, 1 bpp, 8 bytes per row); SHALL be fixed at 256.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_start  input  1  single-cycle request to scan out one frame.
REQ-006 gpu_ready  input  1  high when GPU is idle (no framebuffer writes in flight).
REQ-007 mem_read  output  1  read request, held until ack.
REQ-008 mem_read_addr  output  12  byte address of read.
REQ-009 mem_read_data  input  8  read data, valid with ack.
REQ-010 mem_read_ack  input  1  read completion strobe.
REQ-011 pix_valid  output  1  pixel stream valid.
REQ-012 pix_ready  input  1  downstream accepts pixel.
REQ-013 pix_data  output  1  pixel value (1 = lit).
REQ-014 pix_x  output  6  pixel column 0-63.
REQ-015 pix_y  output  5  pixel row 0-31.
REQ-016 pix_last  output  1  high with final pixel of frame (x=63, y=31).
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 frame_done  output  1  one-cycle pulse after last pixel accepted.

Function
REQ-019 States: IDLE, WAIT_GPU, FETCH, SHIFT.
REQ-020 IDLE: frame_start=1 -> WAIT_GPU next cycle; byte_idx cleared to 0.
REQ-021 WAIT_GPU: gpu_ready=1 -> FETCH; else remain (no timeout).
REQ-022 FETCH: mem_read=1, mem_read_addr=FB_OFFSET+byte_idx every cycle until mem_read_ack; on ack latch mem_read_data into 8-bit shift register, bit_idx=0, -> SHIFT; mem_read deasserts the cycle after ack.
REQ-023 Address arithmetic 12-bit, modulo 4096; no wrap check.
REQ-024 SHIFT: pix_valid=1; pix_data = shift-register MSB (bit 7 = leftmost pixel); pix_x = {byte_idx[2:0], bit_idx[2:0]}; pix_y = byte_idx[7:3].
REQ-025 Pixel accepted when pix_valid && pix_ready; on accept shift left 1, bit_idx+1.
REQ-026 pix_data, pix_x, pix_y, pix_last SHALL hold stable while pix_valid && !pix_ready.
REQ-027 Accept at bit_idx=7: byte_idx<255 -> byte_idx+1, FETCH; byte_idx=255 -> IDLE, frame_done=1 next cycle.
REQ-028 Sustained throughput with pix_ready=1 and 1-cycle ack: 8 pixels per byte plus fetch overhead; no pixel dropped or duplicated.
REQ-029 frame_start while busy SHALL be ignored (not queued).
REQ-030 mem_read_ack outside FETCH SHALL be ignored.
REQ-031 gpu_ready sampled only in WAIT_GPU; later deassertion does not stall scanout.
REQ-032 pix_valid, mem_read low outside SHIFT/FETCH respectively; frame_done low except REQ-027 pulse.

Reset
REQ-033 reset=1 at any clock edge -> IDLE next cycle, overriding all other inputs, including mid-FETCH and mid-SHIFT.
REQ-034 Reset values: mem_read=0, mem_read_addr=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_last=0, busy=0, frame_done=0, byte_idx=0, bit_idx=0, shift register=0.
REQ-035 Abandoned reads not re-issued after reset; a late ack is ignored per REQ-030.

Verification
REQ-036 Memory model with FB[0]=8'hA5, rest 0, ack 1 cycle after request, pix_ready=1, gpu_ready=1, frame_start pulse -> first 8 pixels 1,0,1,0,0,1,0,1 at x=0-7, y=0; 2048 pixels total; pix_last only at x=63,y=31; frame_done one cycle later.
REQ-037 gpu_ready=0 for 20 cycles after frame_start -> busy=1, mem_read=0 throughout; first read at FB_OFFSET (12'hF00) after gpu_ready rises.
REQ-038 Random pix_ready backpressure and random 1-5 cycle ack latency, FB[i]=i -> captured stream reconstructs FB exactly; outputs stable during stalls.
REQ-039 frame_start pulsed again mid-frame -> ignored; exactly 2048 pixels and one frame_done.
REQ-040 reset asserted while in SHIFT at byte_idx=100 -> next cycle all outputs at reset values, busy=0; new frame_start yields full correct frame starting at address 12'hF00.
REQ-041 Spurious mem_read_ack in IDLE and SHIFT -> no state change, no shift-register update.

Source files
------------

// File: rtl/fb_scanout_if.sv
// Bus bundle for the framebuffer scanout engine: shared-memory read port
// plus the outgoing pixel stream. The scanout engine is the master.
interface fb_scanout_if;
  logic        mem_read;
  logic [11:0] mem_read_addr;
  logic [7:0]  mem_read_data;
  logic        mem_read_ack;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_data;
  logic [5:0]  pix_x;
  logic [4:0]  pix_y;
  logic        pix_last;

  modport master (
    output mem_read, mem_read_addr,
    input  mem_read_data, mem_read_ack,
    output pix_valid, pix_data, pix_x, pix_y, pix_last,
    input  pix_ready
  );

  modport slave (
    input  mem_read, mem_read_addr,
    output mem_read_data, mem_read_ack,
    input  pix_valid, pix_data, pix_x, pix_y, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/fb_scanout.sv
// Framebuffer scanout: waits for the GPU to go idle, then reads the 64x32
// 1 bpp framebuffer one byte at a time from shared memory and streams it out
// MSB-first as individually addressed pixels with valid/ready handshaking.
module fb_scanout #(
  parameter logic [11:0] FB_OFFSET = 12'hF00,
  parameter int          FB_BYTES  = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          gpu_ready,
  output logic          busy,
  output logic          frame_done,
  fb_scanout_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GPU = 2'd1,
    FETCH    = 2'd2,
    SHIFT    = 2'd3
  } state_t;

  localparam logic [7:0] LAST_BYTE = 8'(FB_BYTES - 1);

  state_t     state;
  logic [7:0] byte_idx;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       accept;

  // The leftmost not-yet-sent pixel always sits in the MSB of the shift register.
  assign bus.pix_data = shreg[7];
  assign accept       = bus.pix_valid && bus.pix_ready;

  // Scanout FSM with all control and pixel-position outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      byte_idx          <= 8'd0;
      bit_idx           <= 3'd0;
      shreg             <= 8'd0;
      bus.mem_read      <= 1'b0;
      bus.mem_read_addr <= 12'd0;
      bus.pix_valid     <= 1'b0;
      bus.pix_x         <= 6'd0;
      bus.pix_y         <= 5'd0;
      bus.pix_last      <= 1'b0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state    <= WAIT_GPU;
            byte_idx <= 8'd0;
            busy     <= 1'b1;
          end
        end

        WAIT_GPU: begin
          // gpu_ready only matters here; once scanout starts it is not re-checked.
          if (gpu_ready) begin
            state             <= FETCH;
            bus.mem_read      <= 1'b1;
            bus.mem_read_addr <= FB_OFFSET + {4'd0, byte_idx};
          end
        end

        FETCH: begin
          if (bus.mem_read_ack) begin
            state         <= SHIFT;
            shreg         <= bus.mem_read_data;
            bit_idx       <= 3'd0;
            bus.mem_read  <= 1'b0;
            bus.pix_valid <= 1'b1;
            bus.pix_x     <= {byte_idx[2:0], 3'd0};
            bus.pix_y     <= byte_idx[7:3];
            bus.pix_last  <= 1'b0;
          end
        end

        SHIFT: begin
          if (accept) begin
            if (bit_idx == 3'd7) begin
              bus.pix_valid <= 1'b0;
              bus.pix_last  <= 1'b0;
              if (byte_idx == LAST_BYTE) begin
                state      <= IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                state             <= FETCH;
                byte_idx          <= byte_idx + 8'd1;
                bus.mem_read      <= 1'b1;
                bus.mem_read_addr <= FB_OFFSET + {4'd0, byte_idx + 8'd1};
              end
            end else begin
              shreg        <= {shreg[6:0], 1'b0};
              bit_idx      <= bit_idx + 3'd1;
              bus.pix_x    <= {byte_idx[2:0], bit_idx + 3'd1};
              bus.pix_last <= (byte_idx == LAST_BYTE) && (bit_idx == 3'd6);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
